// File: rtl/bus_source_arbiter.sv
// bus_source_arbiter
//   Registered bus-source select. Turns N_SRC request lines into a binary
//   bus-mux select, using fixed-priority or round-robin arbitration.
//   Adds a valid flag, a multi-request error flag and a grant lock for
//   multi-cycle transfers.
//   Optional feature macro: BUS_CONFLICT_CNT_EN adds a saturating
//   conflict_cnt output that counts multi-request edges.
module bus_source_arbiter #(
   parameter int unsigned N_SRC = 24,
   parameter int unsigned SEL_W = 5,
   parameter int unsigned CNT_W = 8
) (
   input  logic             clk,
   input  logic             clr,
   input  logic [N_SRC-1:0] req,
   input  logic             rr_mode,
   input  logic             lock,
   output logic [SEL_W-1:0] sel,
   output logic             sel_valid,
   output logic             multi_err
`ifdef BUS_CONFLICT_CNT_EN
   ,
   output logic [CNT_W-1:0] conflict_cnt
`endif
);

   localparam int unsigned IDX_W = $clog2(N_SRC);

   // Elaboration-time parameter sanity checks
   if ((N_SRC < 2) || (N_SRC > 64)) begin : g_bad_n_src
      $error("bus_source_arbiter: N_SRC must be in 2..64");
   end
   if ((2 ** SEL_W) < N_SRC) begin : g_bad_sel_w
      $error("bus_source_arbiter: SEL_W too narrow for N_SRC");
   end
   if (CNT_W < 1) begin : g_bad_cnt_w
      $error("bus_source_arbiter: CNT_W must be at least 1");
   end

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ACTIVE,
      ST_LOCKED
   } state_e;

   state_e             state_q, state_d;
   logic [SEL_W-1:0]   sel_q, sel_d;
   logic               sel_valid_q, sel_valid_d;
   logic               multi_err_q, multi_err_d;
   logic [SEL_W-1:0]   rr_ptr_q, rr_ptr_d;

   logic               any_req;
   logic [N_SRC-1:0]   above_mask;
   logic [N_SRC-1:0]   rr_high;
   logic [SEL_W-1:0]   fp_win;
   logic [SEL_W-1:0]   rr_win;
   logic [SEL_W-1:0]   win;
   logic               grant;

   // Index of the lowest set bit; zero when the vector is empty
   function automatic logic [SEL_W-1:0] lowest_set(input logic [N_SRC-1:0] v);
      logic [SEL_W-1:0] r;
      logic             hit;
      r   = '0;
      hit = 1'b0;
      for (int unsigned i = 0; i < N_SRC; i++) begin
         if (!hit && v[IDX_W'(i)]) begin
            r   = SEL_W'(i);
            hit = 1'b1;
         end
      end
      return r;
   endfunction

   // Mask of source indices strictly above the round-robin pointer
   always_comb begin
      above_mask = '0;
      for (int unsigned i = 0; i < N_SRC; i++) begin
         above_mask[IDX_W'(i)] = (SEL_W'(i) > rr_ptr_q);
      end
   end

   // Winner selection for both arbitration modes
   // Round-robin scan rr_ptr+1 .. N_SRC-1, wrap to 0 .. rr_ptr, is done as
   // "lowest requester above the pointer, else lowest requester overall".
   always_comb begin
      any_req = |req;
      rr_high = req & above_mask;
      fp_win  = lowest_set(req);
      rr_win  = (|rr_high) ? lowest_set(rr_high) : lowest_set(req);
      win     = rr_mode ? rr_win : fp_win;
   end

   // Next-state, grant and pointer logic
   always_comb begin
      state_d     = state_q;
      sel_d       = sel_q;
      sel_valid_d = sel_valid_q;
      rr_ptr_d    = rr_ptr_q;
      grant       = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (any_req) begin
               grant = 1'b1;
            end
         end
         ST_ACTIVE: begin
            if (!any_req) begin
               state_d     = ST_IDLE;
               sel_valid_d = 1'b0;
            end else if (lock) begin
               state_d = ST_LOCKED;
            end else begin
               grant = 1'b1;
            end
         end
         ST_LOCKED: begin
            if (!lock) begin
               if (any_req) begin
                  grant = 1'b1;
               end else begin
                  state_d     = ST_IDLE;
                  sel_valid_d = 1'b0;
               end
            end
         end
         default: begin
            state_d     = ST_IDLE;
            sel_valid_d = 1'b0;
         end
      endcase

      if (grant) begin
         state_d     = ST_ACTIVE;
         sel_d       = win;
         sel_valid_d = 1'b1;
         if (rr_mode) begin
            rr_ptr_d = win;
         end
      end
   end

   // Multi-request detection, evaluated in every state
   always_comb begin
      multi_err_d = ($countones(req) > 1);
   end

   // State and output registers
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         state_q     <= ST_IDLE;
         sel_q       <= '0;
         sel_valid_q <= 1'b0;
         multi_err_q <= 1'b0;
         rr_ptr_q    <= SEL_W'(N_SRC - 1);
      end else begin
         state_q     <= state_d;
         sel_q       <= sel_d;
         sel_valid_q <= sel_valid_d;
         multi_err_q <= multi_err_d;
         rr_ptr_q    <= rr_ptr_d;
      end
   end

   assign sel       = sel_q;
   assign sel_valid = sel_valid_q;
   assign multi_err = multi_err_q;

`ifdef BUS_CONFLICT_CNT_EN
   logic [CNT_W-1:0] conflict_cnt_q, conflict_cnt_d;

   // Saturating count of edges that see more than one request
   always_comb begin
      conflict_cnt_d = conflict_cnt_q;
      if (multi_err_d && (conflict_cnt_q != '1)) begin
         conflict_cnt_d = conflict_cnt_q + 1'b1;
      end
   end

   // Conflict counter register, cleared only by reset
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         conflict_cnt_q <= '0;
      end else begin
         conflict_cnt_q <= conflict_cnt_d;
      end
   end

   assign conflict_cnt = conflict_cnt_q;
`endif

endmodule

// File: tb/tb_bus_source_arbiter.sv
// tb_bus_source_arbiter
//   Directed stimulus with hand-computed expectations pushed into a
//   scoreboard queue; an independent monitor pops and compares after each
//   rising edge and after each asynchronous reset assertion.
module tb_bus_source_arbiter;

   logic        clk;
   logic        clr;
   logic [23:0] req;
   logic        rr_mode;
   logic        lock;
   logic [4:0]  sel;
   logic        sel_valid;
   logic        multi_err;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [4:0] sel;
      logic       valid;
      logic       merr;
      string      name;
   } exp_t;

   exp_t exp_q[$];

   bus_source_arbiter #(
      .N_SRC(24),
      .SEL_W(5),
      .CNT_W(8)
   ) dut (
      .clk       (clk),
      .clr       (clr),
      .req       (req),
      .rr_mode   (rr_mode),
      .lock      (lock),
      .sel       (sel),
      .sel_valid (sel_valid),
      .multi_err (multi_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [23:0] b(input int i);
      logic [23:0] one;
      one = 24'd1;
      return one << i;
   endfunction

   task automatic push_exp(input int s, input logic v, input logic m, input string nm);
      exp_t e;
      e.sel   = 5'(s);
      e.valid = v;
      e.merr  = m;
      e.name  = nm;
      exp_q.push_back(e);
   endtask

   // Drive one cycle of inputs at the falling edge and queue its expectation
   task automatic step(input logic [23:0] r, input logic rr, input logic lk,
                       input int s, input logic v, input logic m, input string nm);
      @(negedge clk);
      req     = r;
      rr_mode = rr;
      lock    = lk;
      push_exp(s, v, m, nm);
   endtask

   // Assert reset between edges and expect outputs cleared immediately
   task automatic async_reset(input string nm);
      @(negedge clk);
      #2;
      push_exp(0, 1'b0, 1'b0, nm);
      clr = 1'b0;
      @(negedge clk);
      req  = '0;
      lock = 1'b0;
      @(negedge clk);
      clr = 1'b1;
   endtask

   // Monitor: compare outputs against the oldest queued expectation
   initial begin
      exp_t e;
      forever begin
         @(posedge clk or negedge clr);
         #1;
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            checks++;
            if (sel !== e.sel || sel_valid !== e.valid || multi_err !== e.merr) begin
               errors++;
               $display("FAIL %s: got sel=%0d sel_valid=%0b multi_err=%0b, expected sel=%0d sel_valid=%0b multi_err=%0b",
                        e.name, sel, sel_valid, multi_err, e.sel, e.valid, e.merr);
            end
         end
      end
   end

   // Watchdog
   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, %0d expectations pending", exp_q.size());
      errors++;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $fatal(1);
   end

   // Stimulus
   initial begin
      clr     = 1'b1;
      req     = '0;
      rr_mode = 1'b0;
      lock    = 1'b0;
      #1;
      push_exp(0, 1'b0, 1'b0, "reset_state");
      clr = 1'b0;
      @(negedge clk);
      @(negedge clk);
      clr = 1'b1;

      // Fixed priority
      step(b(0) | b(5), 1'b0, 1'b0,  0, 1'b1, 1'b1, "fp_0_5");
      step('0,          1'b0, 1'b0,  0, 1'b0, 1'b0, "fp_idle");
      step(b(5) | b(9), 1'b0, 1'b0,  5, 1'b1, 1'b1, "fp_5_9");
      step(b(9),        1'b0, 1'b0,  9, 1'b1, 1'b0, "fp_9");
      step('0,          1'b0, 1'b0,  9, 1'b0, 1'b0, "fp_idle_hold");

      // Round-robin alternation
      step(b(3) | b(7), 1'b1, 1'b0,  3, 1'b1, 1'b1, "rr_3_7_a");
      step(b(3) | b(7), 1'b1, 1'b0,  7, 1'b1, 1'b1, "rr_3_7_b");
      step(b(3) | b(7), 1'b1, 1'b0,  3, 1'b1, 1'b1, "rr_3_7_c");
      step(b(3) | b(7), 1'b1, 1'b0,  7, 1'b1, 1'b1, "rr_3_7_d");

      // Round-robin wrap
      step(b(23),         1'b1, 1'b0, 23, 1'b1, 1'b0, "rr_23");
      step(b(0) | b(23),  1'b1, 1'b0,  0, 1'b1, 1'b1, "rr_wrap_0");
      step(b(0) | b(23),  1'b1, 1'b0, 23, 1'b1, 1'b1, "rr_wrap_23");
      step('0,            1'b1, 1'b0, 23, 1'b0, 1'b0, "rr_idle");

      // Lock without a grant has no effect
      step('0,            1'b1, 1'b1, 23, 1'b0, 1'b0, "lock_idle_noreq");

      // Lock holds the grant
      step(b(4),          1'b1, 1'b0,  4, 1'b1, 1'b0, "grant_4");
      step(b(9),          1'b1, 1'b1,  4, 1'b1, 1'b0, "lock_enter");
      step(b(9),          1'b1, 1'b1,  4, 1'b1, 1'b0, "lock_hold_1");
      step(b(9),          1'b1, 1'b1,  4, 1'b1, 1'b0, "lock_hold_2");
      step(b(1) | b(2),   1'b1, 1'b1,  4, 1'b1, 1'b1, "lock_merr");
      step(b(9),          1'b1, 1'b0,  9, 1'b1, 1'b0, "lock_release");
      step('0,            1'b1, 1'b1,  9, 1'b0, 1'b0, "lock_noreq_idle");

      // Lock released with no requests
      step(b(2),          1'b1, 1'b0,  2, 1'b1, 1'b0, "grant_2");
      step(b(2),          1'b1, 1'b1,  2, 1'b1, 1'b0, "lock2_enter");
      step('0,            1'b1, 1'b1,  2, 1'b1, 1'b0, "lock2_ignore_req");
      step('0,            1'b1, 1'b0,  2, 1'b0, 1'b0, "lock2_release_idle");

      // Reset mid-lock
      step(b(6),          1'b1, 1'b0,  6, 1'b1, 1'b0, "grant_6");
      step(b(6),          1'b1, 1'b1,  6, 1'b1, 1'b0, "lock6_enter");
      step(b(6) | b(8),   1'b1, 1'b1,  6, 1'b1, 1'b1, "lock6_merr");
      async_reset("reset_mid_lock");
      step(b(20),          1'b1, 1'b0, 20, 1'b1, 1'b0, "post_reset_20");
      step(b(20) | b(21),  1'b1, 1'b0, 21, 1'b1, 1'b1, "rr_20_21");
      step(b(21) | b(3),   1'b0, 1'b0,  3, 1'b1, 1'b1, "fp_3_21");
      step(b(21) | b(3),   1'b1, 1'b0,  3, 1'b1, 1'b1, "rr_ptr_kept_in_fp");
      step('0,             1'b1, 1'b0,  3, 1'b0, 1'b0, "idle_3");

      // Reset restores the round-robin pointer to the top source
      async_reset("reset_idle");
      step(b(0) | b(23),   1'b1, 1'b0,  0, 1'b1, 1'b1, "rr_ptr_reset");
      step('0,             1'b1, 1'b0,  0, 1'b0, 1'b0, "final_idle");

      for (int k = 0; k < 5 && exp_q.size() != 0; k++) begin
         @(posedge clk);
      end
      #2;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
